instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter INS_ADDRESS, default 9, meaning byte-address width of the instruction memory port.
REQ-002 SHALL have parameter INS_W, default 32, meaning instruction width.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ra  output  INS_ADDRESS  read address to the instruction memory, equal to the current PC.
REQ-006 SHALL have port rd  input  INS_W  instruction word returned combinationally for ra in the same cycle.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump taken; load new PC this cycle.
REQ-008 SHALL have port redirect_pc  input  INS_ADDRESS  target byte address of the redirect.
REQ-009 SHALL have port if_valid  output  1  if_instr/if_pc hold a valid fetched instruction.
REQ-010 SHALL have port if_ready  input  1  decode stage accepts the head instruction.
REQ-011 SHALL have port if_instr  output  INS_W  head instruction word.
REQ-012 SHALL have port if_pc  output  INS_ADDRESS  byte address of the head instruction.
REQ-013 SHALL have port misalign_err  output  1  sticky flag, set by a misaligned redirect.

Function
REQ-014 SHALL hold a PC register; ra SHALL equal PC combinationally, with PC[1:0] always 2'b00.
REQ-015 SHALL buffer fetched {pc, instruction} pairs in a 2-entry FIFO whose occupancy states are EMPTY, ONE and FULL.
REQ-016 SHALL define pop = if_valid & if_ready, and push = !redirect_valid & (state != FULL | pop).
REQ-017 On push, SHALL write {PC, rd} into the FIFO tail and advance PC by 4 at the same rising edge.
REQ-018 PC addition SHALL wrap modulo 2^INS_ADDRESS: 0x1FC + 4 = 0x000 for the default width.
REQ-019 State transitions: EMPTY->ONE on push; ONE->FULL on push & !pop; ONE->EMPTY on pop & !push; FULL->ONE on pop & !push; simultaneous push & pop SHALL leave the state unchanged.
REQ-020 if_valid SHALL be 1 exactly when state != EMPTY; if_instr and if_pc SHALL come from the FIFO head register, not from rd.
REQ-021 When if_valid=1 and if_ready=0, if_instr and if_pc SHALL remain stable until the pop.
REQ-022 When FULL and no pop occurs, PC SHALL hold and no push SHALL occur.
REQ-023 On redirect_valid=1, at the next edge: FIFO flushed to EMPTY, PC <= {redirect_pc[INS_ADDRESS-1:2], 2'b00}, and no push; a pop in the same cycle SHALL still count as accepted by decode.
REQ-024 Redirect SHALL take priority over push and over the FULL hold.
REQ-025 If redirect_valid=1 and redirect_pc[1:0] != 0, misalign_err SHALL set at the next edge and stay set until reset.
REQ-026 Fetch latency SHALL be one cycle: an instruction at PC sampled at edge N SHALL appear on if_instr with if_valid=1 after edge N.

Reset
REQ-027 While rst_n=0, SHALL asynchronously force PC=0, state=EMPTY, if_valid=0, if_instr=0, if_pc=0 and misalign_err=0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered instructions; after release, fetch SHALL restart at address 0.
REQ-029 The first push SHALL occur at the first rising edge with rst_n=1.

Verification
REQ-030 Reset release with mem[0]=0x00007033, mem[1]=0x00100093, if_ready=1 -> edge 1: if_valid=1, if_instr=0x00007033, if_pc=0x000; edge 2: if_instr=0x00100093, if_pc=0x004.
REQ-031 if_ready=0 for 5 cycles after reset -> FIFO holds pc 0x000 and 0x004, ra stays 0x008, if_instr remains 0x00007033; one cycle of if_ready=1 -> head becomes pc 0x004, ra becomes 0x00C.
REQ-032 redirect_valid=1 with redirect_pc=0x020 while FULL -> next cycle if_valid=0 and ra=0x020; the following cycle if_pc=0x020 with if_instr=mem[8]=0x00208433.
REQ-033 redirect_pc=0x1FC, if_ready=1 -> if_pc sequence is 0x1FC, then 0x000, then 0x004 (wrap-around).
REQ-034 redirect_pc=0x022 -> misalign_err=1, next if_pc=0x020; misalign_err stays 1 through later redirects until rst_n=0.
REQ-035 rst_n pulsed low while FULL -> if_valid=0 immediately (asynchronous), and after release the first if_pc=0x000.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, combinational memory read and a 2-entry
// {pc, instr} skid FIFO feeding decode, with redirect flush and sticky misalign flag.
module instruction_fetch #(
  parameter int unsigned INS_ADDRESS = 9,
  parameter int unsigned INS_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [INS_ADDRESS-1:0] ra,
  input  logic [INS_W-1:0]       rd,
  input  logic                   redirect_valid,
  input  logic [INS_ADDRESS-1:0] redirect_pc,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [INS_W-1:0]       if_instr,
  output logic [INS_ADDRESS-1:0] if_pc,
  output logic                   misalign_err
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e                 state_q, state_d;
  logic [INS_ADDRESS-1:0] pc_q, pc_d;
  logic [INS_ADDRESS-1:0] head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
  logic [INS_W-1:0]       head_instr_q, head_instr_d, tail_instr_q, tail_instr_d;
  logic                   misalign_q, misalign_d;
  logic                   pop, push;

  assign pop  = if_valid & if_ready;
  assign push = ~redirect_valid & ((state_q != StFull) | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      pc_q         <= '0;
      head_pc_q    <= '0;
      head_instr_q <= '0;
      tail_pc_q    <= '0;
      tail_instr_q <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      tail_pc_q    <= tail_pc_d;
      tail_instr_q <= tail_instr_d;
      misalign_q   <= misalign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: if (push) state_d = StOne;
        StOne: begin
          if (push && !pop)      state_d = StFull;
          else if (pop && !push) state_d = StEmpty;
        end
        StFull:  if (pop && !push) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    pc_d         = pc_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    tail_pc_d    = tail_pc_q;
    tail_instr_d = tail_instr_q;
    misalign_d   = misalign_q | (redirect_valid & (|redirect_pc[1:0]));
    if (redirect_valid) begin
      pc_d = {redirect_pc[INS_ADDRESS-1:2], 2'b00};
    end else begin
      // Draining a full FIFO shifts the tail up before the new word lands in the tail.
      if (pop && state_q == StFull) begin
        head_pc_d    = tail_pc_q;
        head_instr_d = tail_instr_q;
      end
      if (push) begin
        pc_d = pc_q + INS_ADDRESS'(4);
        if (state_q == StEmpty || (state_q == StOne && pop)) begin
          head_pc_d    = pc_q;
          head_instr_d = rd;
        end else begin
          tail_pc_d    = pc_q;
          tail_instr_d = rd;
        end
      end
    end
  end

  always_comb begin
    ra           = pc_q;
    if_valid     = (state_q != StEmpty);
    if_instr     = head_instr_q;
    if_pc        = head_pc_q;
    misalign_err = misalign_q;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed sequences, accepted instructions checked
// against an expectation queue by a negedge monitor, plus direct state checks.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  ra;
  logic [31:0] rd;
  logic        redirect_valid;
  logic [8:0]  redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [8:0]  if_pc;
  logic        misalign_err;

  typedef struct packed {
    logic [8:0]  pc;
    logic [31:0] instr;
  } fetch_t;

  fetch_t      exp_q[$];
  logic [31:0] mem [0:127];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign rd = mem[ra[8:2]];

  instruction_fetch #(
    .INS_ADDRESS(9),
    .INS_W      (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ra            (ra),
    .rd            (rd),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .misalign_err  (misalign_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input logic [8:0] pc);
    fetch_t e;
    e.pc    = pc;
    e.instr = mem[pc[8:2]];
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Monitor: every instruction decode accepts must match the next expectation.
  always @(negedge clk) begin
    if (rst_n && if_valid && if_ready) begin
      fetch_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc %h instr %h expected no accept", if_pc, if_instr);
      end else begin
        e = exp_q.pop_front();
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          errors++;
          $display("FAIL sb_accept: got pc %h instr %h expected pc %h instr %h",
                   if_pc, if_instr, e.pc, e.instr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = {16'hc0de, 16'(i)};
    mem[0] = 32'h00007033;
    mem[1] = 32'h00100093;
    mem[8] = 32'h00208433;
    rst_n          = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    #2;
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_ra", 32'(ra), 32'h0);
    chk("rst_pc", 32'(if_pc), 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    tick();
    rst_n = 1'b1;

    // One-cycle fetch latency from reset release.
    if_ready = 1'b1;
    expect_fetch(9'h000);
    tick();
    chk("t1_valid", 32'(if_valid), 32'd1);
    chk("t1_pc0", 32'(if_pc), 32'h000);
    chk("t1_instr0", if_instr, 32'h00007033);
    tick();
    chk("t1_pc1", 32'(if_pc), 32'h004);
    chk("t1_instr1", if_instr, 32'h00100093);
    if_ready = 1'b0;

    // Backpressure fills the FIFO and stalls the PC.
    do_reset();
    repeat (5) tick();
    chk("t2_ra_hold", 32'(ra), 32'h008);
    chk("t2_head_pc", 32'(if_pc), 32'h000);
    chk("t2_head_instr", if_instr, 32'h00007033);
    chk("t2_valid", 32'(if_valid), 32'd1);
    expect_fetch(9'h000);
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    chk("t2_pop_pc", 32'(if_pc), 32'h004);
    chk("t2_pop_ra", 32'(ra), 32'h00c);

    // Redirect while full flushes and restarts at the target.
    redirect_valid = 1'b1;
    redirect_pc    = 9'h020;
    tick();
    redirect_valid = 1'b0;
    chk("t3_flush_valid", 32'(if_valid), 32'd0);
    chk("t3_flush_ra", 32'(ra), 32'h020);
    tick();
    chk("t3_tgt_pc", 32'(if_pc), 32'h020);
    chk("t3_tgt_instr", if_instr, 32'h00208433);
    chk("t3_tgt_valid", 32'(if_valid), 32'd1);

    // Redirect with a simultaneous pop; then PC wraps past the top of memory.
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 9'h1fc;
    expect_fetch(9'h020);
    tick();
    redirect_valid = 1'b0;
    chk("t4_flush_valid", 32'(if_valid), 32'd0);
    expect_fetch(9'h1fc);
    expect_fetch(9'h000);
    tick();
    chk("t4_wrap_a", 32'(if_pc), 32'h1fc);
    tick();
    chk("t4_wrap_b", 32'(if_pc), 32'h000);
    tick();
    chk("t4_wrap_c", 32'(if_pc), 32'h004);
    if_ready = 1'b0;
    chk("t4_no_misalign", 32'(misalign_err), 32'd0);

    // Misaligned redirect sets a sticky flag and is masked to word alignment.
    redirect_valid = 1'b1;
    redirect_pc    = 9'h022;
    tick();
    redirect_valid = 1'b0;
    chk("t5_misalign_set", 32'(misalign_err), 32'd1);
    tick();
    chk("t5_masked_pc", 32'(if_pc), 32'h020);
    redirect_valid = 1'b1;
    redirect_pc    = 9'h040;
    tick();
    redirect_valid = 1'b0;
    chk("t5_misalign_sticky", 32'(misalign_err), 32'd1);
    tick();
    chk("t5_aligned_pc", 32'(if_pc), 32'h040);

    // Fill, confirm hold, then asynchronous reset mid-operation.
    tick();
    chk("t6_full_ra", 32'(ra), 32'h048);
    tick();
    chk("t6_hold_ra", 32'(ra), 32'h048);
    chk("t6_hold_pc", 32'(if_pc), 32'h040);
    rst_n = 1'b0;
    #2;
    chk("t6_async_valid", 32'(if_valid), 32'd0);
    chk("t6_async_pc", 32'(if_pc), 32'h0);
    chk("t6_async_ra", 32'(ra), 32'h0);
    chk("t6_async_misalign", 32'(misalign_err), 32'd0);
    #2;
    rst_n    = 1'b1;
    if_ready = 1'b1;
    expect_fetch(9'h000);
    tick();
    chk("t6_restart_pc", 32'(if_pc), 32'h000);
    chk("t6_restart_valid", 32'(if_valid), 32'd1);
    tick();
    if_ready = 1'b0;
    tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
